uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_cnt.sv | 47 ++++
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter: frame-controller state type,
// parity-mode encodings, data width and the parity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Parity-mode encodings used by the PARITY parameter of uart_tx.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
        return (^d) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Per-bit cycle counter. Counts 0 .. CLKS_PER_BIT-1 and pulses bit_done_o on
// the last cycle of each bit, then wraps to 0 so the next bit starts cleanly.
// Ports:
//   clk        in   system clock (rising edge)
//   rst        in   synchronous active-high reset
//   restart_i  in   hold the counter at 0 (asserted while the line is idle)
//   bit_done_o out  high on the final cycle of the current bit
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done_o = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so
        // no path can leave it unassigned and infer a latch.
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || bit_done_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity,
// STOP_BITS stop bits, each bit held for CLKS_PER_BIT cycles. tx and busy are
// registered; they are computed from the next state so they change on the
// same edge as the state register.
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
// Ports:
//   clk         in   system clock (rising edge)
//   rst         in   synchronous active-high reset, aborts any frame
//   data[7:0]   in   byte to transmit, latched when a frame is accepted
//   data_valid  in   level-sensitive transmit request, sampled only in idle
//   tx          out  serial line, idle high
//   busy        out  high for exactly the frame length
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 tx,
    output logic                 busy
);

    state_e               state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_q,     par_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q,      tx_d;
    logic                 busy_q,    busy_d;

    logic                 bit_done;

    // The counter idles at 0, so the first bit after acceptance is full length.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk        (clk),
        .rst        (rst),
        .restart_i  (state_q == ST_IDLE),
        .bit_done_o (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (data_valid) begin
                    state_d   = ST_START;
                    shift_d   = data;
                    // Parity is captured with the byte so later data changes
                    // cannot disturb the frame in flight.
                    par_d     = parity_bit(data, PARITY);
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_done) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end

            ST_STOP: begin
                // bit_idx counts stop bits here.
                if (bit_done) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            // NOTE: the shift register is cleared on reset too, so no stale
            // byte survives an aborted frame.
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Drives four uart_tx instances (no parity, even, odd, and a short-bit
// even-parity two-stop-bit variant) with the same directed stimulus. A
// frame-level model predicts tx/busy every cycle; directed literal checks pin
// the model to hand-computed frames.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NI = 4;
    localparam int C_T [NI] = '{16, 16, 16, 4};
    localparam int P_T [NI] = '{0, 1, 2, 1};
    localparam int S_T [NI] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       data_valid;
    logic       tx_w   [NI];
    logic       busy_w [NI];

    int checks   = 0;
    int failures = 0;

    uart_tx #(.CLKS_PER_BIT(C_T[0]), .PARITY(P_T[0]), .STOP_BITS(S_T[0])) dut0 (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.CLKS_PER_BIT(C_T[1]), .PARITY(P_T[1]), .STOP_BITS(S_T[1])) dut1 (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.CLKS_PER_BIT(C_T[2]), .PARITY(P_T[2]), .STOP_BITS(S_T[2])) dut2 (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.CLKS_PER_BIT(C_T[3]), .PARITY(P_T[3]), .STOP_BITS(S_T[3])) dut3 (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .tx(tx_w[3]), .busy(busy_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // A frame is a list of bit values; tx shows bit (elapsed / CLKS_PER_BIT)
    // for frame_len cycles after the accepting edge, then the line is idle.
    bit          m_act  [NI];
    int          m_el   [NI];
    int          m_len  [NI];
    logic [15:0] m_bits [NI];
    bit          model_ok = 1'b0;

    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
        logic [15:0] b;
        b = '1;                          // stop bits and beyond are 1
        b[0] = 1'b0;
        for (int j = 0; j < 8; j++) b[1 + j] = d[j];
        if (par != 0) b[9] = (^d) ^ (par == 2);
        return b;
    endfunction

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 1'b0;
            m_el[i]  = 0;
            m_len[i] = (1 + 8 + ((P_T[i] != 0) ? 1 : 0) + S_T[i]) * C_T[i];
            m_bits[i] = '1;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
                    m_el[i]++;
                    if (m_el[i] == m_len[i]) m_act[i] = 1'b0;
                end else if (data_valid) begin
                    m_act[i]  = 1'b1;
                    m_el[i]   = 0;
                    m_bits[i] = frame_bits(data, P_T[i]);
                end
            end
            if (rst) model_ok = 1'b1;
            @(negedge clk);
            if (model_ok) begin
                for (int i = 0; i < NI; i++) begin
                    check($sformatf("busy[%0d]", i), busy_w[i], m_act[i]);
                    check($sformatf("tx[%0d]", i), tx_w[i],
                          m_act[i] ? m_bits[i][m_el[i] / C_T[i]] : 1'b1);
                end
            end
        end
    end

    // ------------------------------------------------------- capture helper
    // Starts at the negedge that is cycle 0 of a frame; records busy counts
    // and mid-bit tx samples of the 16-cycle instances.
    int          cap_busy [NI];
    logic [11:0] cap_bit  [3];

    task automatic capture(input int ncyc);
        for (int i = 0; i < NI; i++) cap_busy[i] = 0;
        for (int i = 0; i < 3; i++) cap_bit[i] = '1;
        for (int k = 0; k < ncyc; k++) begin
            for (int i = 0; i < NI; i++) if (busy_w[i]) cap_busy[i]++;
            if ((k % 16) == 8 && (k / 16) < 12)
                for (int i = 0; i < 3; i++) cap_bit[i][k / 16] = tx_w[i];
            @(negedge clk);
        end
    endtask

    logic [9:0] bits0;
    logic       tr_tx   [400];
    logic       tr_busy [400];

    initial begin
        int   rises;
        logic prevb;
        int   fall;
        int   gap;
        int   start2;
        logic [7:0] b1, b2;

        rst = 1'b1;
        data_valid = 1'b0;
        data = 8'h00;

        // Reset then a long idle stretch.
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_tx", tx_w[0], 1'b1);
        check("idle_busy", busy_w[0], 1'b0);

        // Single frame 0x7B; data is scrambled right after acceptance.
        data = 8'h7B;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data = 8'hFF;
        capture(200);
        check("frame7B_bits", cap_bit[0][9:0], 10'h2F6);
        check("frame7B_busy", cap_busy[0], 160);
        check("even7B_par", cap_bit[1][9], 1'b0);
        check("odd7B_par", cap_bit[2][9], 1'b1);
        check("even7B_stop", cap_bit[1][10], 1'b1);
        check("even_busy", cap_busy[1], 176);
        check("odd_busy", cap_busy[2], 176);
        check("short_busy", cap_busy[3], 48);

        // Data change mid-frame while data_valid stays high for 130 cycles.
        data = 8'h00;
        data_valid = 1'b1;
        rises = 0;
        prevb = 1'b0;
        bits0 = '1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (busy_w[0] && !prevb) rises++;
            prevb = busy_w[0];
            if (((n - 1) % 16) == 8 && ((n - 1) / 16) < 10) bits0[(n - 1) / 16] = tx_w[0];
            if (n == 80) data = 8'h7B;
            if (n == 130) data_valid = 1'b0;
        end
        check("chg_frames", rises, 1);
        check("chg_bits", bits0, 10'h200);

        // Back-to-back frames with data_valid held high.
        data = 8'hA5;
        data_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            tr_tx[n]   = tx_w[0];
            tr_busy[n] = busy_w[0];
        end
        data_valid = 1'b0;
        fall = 0;
        while (fall < 399 && tr_busy[fall]) fall++;
        gap = 0;
        while (fall + gap < 399 && !tr_busy[fall + gap]) gap++;
        start2 = fall + gap;
        check("b2b_len", fall, 160);
        check("b2b_gap", gap, 1);
        for (int j = 0; j < 8; j++) begin
            b1[j] = tr_tx[24 + 16 * j];
            b2[j] = (start2 + 24 + 16 * j < 400) ? tr_tx[start2 + 24 + 16 * j] : 1'bx;
        end
        check("b2b_byte1", b1, 8'hA5);
        check("b2b_byte2", b2, 8'hA5);
        repeat (200) @(negedge clk);

        // Reset at cycle 50 of a frame, then a clean new frame.
        data = 8'h3C;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_tx[%0d]", i), tx_w[i], 1'b1);
            check($sformatf("rst_busy[%0d]", i), busy_w[i], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        data = 8'h96;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        capture(200);
        check("post_rst_bits", cap_bit[0][9:0], 10'h32C);
        check("post_rst_busy", cap_busy[0], 160);
        check("post_rst_even", cap_bit[1][9], 1'b0);
        check("post_rst_odd", cap_bit[2][9], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
